// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM handshake bundle: EX-side payload and valid/ready, MEM-side registered view.
// slave = the pipeline register, master = whatever drives EX and consumes MEM.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [4:0]            ctrl_in;
    logic [DATA_W-1:0]     branch_tgt_in;
    logic                  zero_in;
    logic [DATA_W-1:0]     alu_res_in;
    logic [DATA_W-1:0]     rt_data_in;
    logic [REG_ADDR_W-1:0] wr_reg_in;

    logic                  out_valid;
    logic                  out_ready;
    logic                  MemToReg;
    logic                  RegWrite;
    logic                  MemRead;
    logic                  MemWrite;
    logic                  Branch;
    logic [DATA_W-1:0]     branch_tgt;
    logic                  zero;
    logic [DATA_W-1:0]     alu_res;
    logic [DATA_W-1:0]     rt_data;
    logic [REG_ADDR_W-1:0] wr_reg;
    logic                  branch_taken;

    modport slave (
        input  in_valid, flush, ctrl_in, branch_tgt_in, zero_in, alu_res_in,
               rt_data_in, wr_reg_in, out_ready,
        output in_ready, out_valid, MemToReg, RegWrite, MemRead, MemWrite, Branch,
               branch_tgt, zero, alu_res, rt_data, wr_reg, branch_taken
    );

    modport master (
        output in_valid, flush, ctrl_in, branch_tgt_in, zero_in, alu_res_in,
               rt_data_in, wr_reg_in, out_ready,
        input  in_ready, out_valid, MemToReg, RegWrite, MemRead, MemWrite, Branch,
               branch_tgt, zero, alu_res, rt_data, wr_reg, branch_taken
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready, flush and valid-gated controls.
// Latency 1 cycle. Backpressure: default single entry, in_ready = !out_valid | out_ready;
// with EX_MEM_SKID_EN a one-entry skid makes in_ready a pure flop (!skid_full).
module ex_mem_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    ex_mem_pipe_reg_if.slave   bus
);

    typedef struct packed {
        logic [4:0]            ctrl;   // {MemToReg,RegWrite,MemRead,MemWrite,Branch}
        logic [DATA_W-1:0]     tgt;
        logic                  zero;
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     rt;
        logic [REG_ADDR_W-1:0] wr;
    } entry_t;

    entry_t in_ent;
    entry_t out_q, out_d;
    logic   out_vld_q, out_vld_d;
    logic   in_rdy;
    logic   xfer_out;

    assign in_ent = '{ctrl: bus.ctrl_in, tgt: bus.branch_tgt_in, zero: bus.zero_in,
                      alu: bus.alu_res_in, rt: bus.rt_data_in, wr: bus.wr_reg_in};

    assign xfer_out = out_vld_q & bus.out_ready;

`ifdef EX_MEM_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_full_q, skid_full_d;

    assign in_rdy = ~skid_full_q;

    always_comb begin
        out_d       = out_q;
        out_vld_d   = out_vld_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (bus.flush) begin
            out_vld_d   = 1'b0;
            skid_full_d = 1'b0;
        end else if (skid_full_q) begin
            // in_ready is low here, so only the drain can happen
            if (xfer_out) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end
        end else if (!out_vld_q || xfer_out) begin
            out_vld_d = bus.in_valid;
            if (bus.in_valid) begin
                out_d = in_ent;
            end
        end else if (bus.in_valid) begin
            skid_d      = in_ent;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    logic xfer_in;

    assign in_rdy  = ~out_vld_q | bus.out_ready;
    assign xfer_in = bus.in_valid & in_rdy;

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (bus.flush) begin
            out_vld_d = 1'b0;
        end else if (xfer_in) begin
            // also covers replace-on-drain when full and out_ready is high
            out_vld_d = 1'b1;
            out_d     = in_ent;
        end else if (xfer_out) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end
`endif

    assign bus.in_ready     = in_rdy;
    assign bus.out_valid    = out_vld_q;
    assign bus.MemToReg     = out_vld_q & out_q.ctrl[4];
    assign bus.RegWrite     = out_vld_q & out_q.ctrl[3];
    assign bus.MemRead      = out_vld_q & out_q.ctrl[2];
    assign bus.MemWrite     = out_vld_q & out_q.ctrl[1];
    assign bus.Branch       = out_vld_q & out_q.ctrl[0];
    assign bus.branch_tgt   = out_q.tgt;
    assign bus.zero         = out_q.zero;
    assign bus.alu_res      = out_q.alu;
    assign bus.rt_data      = out_q.rt;
    assign bus.wr_reg       = out_q.wr;
    assign bus.branch_taken = out_vld_q & out_q.ctrl[0] & out_q.zero;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: vector table, hand sequences for hold/flush/reset, random run vs queue model.
module tb_ex_mem_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 5;
`ifdef EX_MEM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_mem_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    ex_mem_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [4:0]    ctrl;
        logic [DW-1:0] tgt;
        logic          zero;
        logic [DW-1:0] alu;
        logic [DW-1:0] rt;
        logic [AW-1:0] wr;
    } ent_t;

    typedef struct {
        logic          iv, fl, ordy;
        logic [4:0]    ctrl;
        logic [DW-1:0] alu;
        logic          z;
        logic [DW-1:0] tgt;
        logic          e_ov;
        logic [4:0]    e_ctrl;
        logic          e_bt;
    } vec_t;

    ent_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic fl, input logic ordy, input logic [4:0] c,
                         input logic [DW-1:0] a, input logic z, input logic [DW-1:0] t);
        logic [DW-1:0] rt;
        rt = a ^ 32'hDEAD_BEEF;
        bus.in_valid      = iv;
        bus.flush         = fl;
        bus.out_ready     = ordy;
        bus.ctrl_in       = c;
        bus.alu_res_in    = a;
        bus.zero_in       = z;
        bus.branch_tgt_in = t;
        bus.rt_data_in    = rt;
        bus.wr_reg_in     = rt[AW-1:0];
    endtask

    function automatic logic m_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || bus.out_ready;
    endfunction

    function automatic logic [4:0] dut_ctrl();
        return {bus.MemToReg, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch};
    endfunction

    task automatic check_model();
        logic       ov;
        logic [4:0] ec;
        logic       eb;
        ov = q.size() > 0;
        ec = 5'b0;
        eb = 1'b0;
        if (ov) begin
            ec = q[0].ctrl;
            eb = q[0].ctrl[0] & q[0].zero;
        end
        chk("m_out_valid", bus.out_valid, ov);
        chk("m_in_ready", bus.in_ready, m_ready());
        chk("m_ctrl", dut_ctrl(), ec);
        chk("m_branch_taken", bus.branch_taken, eb);
        if (ov) begin
            chk("m_alu_res", bus.alu_res, q[0].alu);
            chk("m_rt_data", bus.rt_data, q[0].rt);
            chk("m_wr_reg", bus.wr_reg, q[0].wr);
            chk("m_branch_tgt", bus.branch_tgt, q[0].tgt);
            chk("m_zero", bus.zero, q[0].zero);
        end
    endtask

    // One clock: compare at negedge, advance the model at the edge, return just after it.
    task automatic step();
        logic acc, xo, fl;
        ent_t e;
        @(negedge clk);
        check_model();
        acc = bus.in_valid && m_ready();
        xo  = (q.size() > 0) && bus.out_ready;
        fl  = bus.flush;
        e   = '{ctrl: bus.ctrl_in, tgt: bus.branch_tgt_in, zero: bus.zero_in,
                alu: bus.alu_res_in, rt: bus.rt_data_in, wr: bus.wr_reg_in};
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (xo) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, bus.out_valid, 1'b0);
        chk({nm, "_ctrl"}, dut_ctrl(), 5'b0);
        chk({nm, "_branch_taken"}, bus.branch_taken, 1'b0);
        chk({nm, "_alu_res"}, bus.alu_res, 32'h0);
        chk({nm, "_rt_data"}, bus.rt_data, 32'h0);
        chk({nm, "_wr_reg"}, bus.wr_reg, 5'h0);
        chk({nm, "_branch_tgt"}, bus.branch_tgt, 32'h0);
        chk({nm, "_zero"}, bus.zero, 1'b0);
    endtask

    initial begin
        logic b_pending;

        //        iv  fl  ordy ctrl       alu     z   tgt      e_ov e_ctrl     e_bt
        tbl[0] = '{1'b1, 1'b0, 1'b1, 5'b01000, 32'h10, 1'b0, 32'h0,   1'b1, 5'b01000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 5'b01000, 32'h20, 1'b0, 32'h0,   1'b1, 5'b01000, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 5'b01000, 32'h30, 1'b0, 32'h0,   1'b1, 5'b01000, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 5'b11111, 32'h40, 1'b1, 32'h0,   1'b0, 5'b00000, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'b00001, 32'h44, 1'b1, 32'h400, 1'b1, 5'b00001, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 5'b00001, 32'h48, 1'b0, 32'h400, 1'b1, 5'b00001, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 5'b01000, 32'h50, 1'b0, 32'h0,   1'b0, 5'b00000, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 5'b10110, 32'h77, 1'b0, 32'h0,   1'b1, 5'b10110, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 5'b10110, 32'h88, 1'b0, 32'h0,   1'b0, 5'b00000, 1'b0};

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk_reset_outputs("reset");
        #10 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release_in_ready", bus.in_ready, 1'b1);

        // Table: continuous out_ready, so both capacity modes agree
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].iv, tbl[i].fl, tbl[i].ordy, tbl[i].ctrl, tbl[i].alu, tbl[i].z, tbl[i].tgt);
            step();
            chk($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].e_ov);
            chk($sformatf("tbl%0d_ctrl", i), dut_ctrl(), tbl[i].e_ctrl);
            chk($sformatf("tbl%0d_branch_taken", i), bus.branch_taken, tbl[i].e_bt);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_alu_res", i), bus.alu_res, tbl[i].alu);
                chk($sformatf("tbl%0d_branch_tgt", i), bus.branch_tgt, tbl[i].tgt);
                chk($sformatf("tbl%0d_zero", i), bus.zero, tbl[i].z);
            end
        end

        // Hold A under stall, offer B
        drive(1'b1, 1'b0, 1'b0, 5'b01000, 32'h10, 1'b0, 32'h0);
        step();
        b_pending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(b_pending, 1'b0, 1'b0, 5'b01000, 32'h20, 1'b0, 32'h0);
            #1;
            chk($sformatf("hold%0d_in_ready", k), bus.in_ready, SKID && (k == 0));
            chk($sformatf("hold%0d_out_valid", k), bus.out_valid, 1'b1);
            chk($sformatf("hold%0d_alu_res", k), bus.alu_res, 32'h10);
            chk($sformatf("hold%0d_RegWrite", k), bus.RegWrite, 1'b1);
            step();
            if (SKID && k == 0) b_pending = 1'b0;
        end
        drive(b_pending, 1'b0, 1'b1, 5'b01000, 32'h20, 1'b0, 32'h0);
        step();
        chk("release_out_valid", bus.out_valid, 1'b1);
        chk("release_alu_res_B", bus.alu_res, 32'h20);
        drive(1'b0, 1'b0, 1'b1, 5'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("release_drained", bus.out_valid, 1'b0);

        // Flush with a held entry (and a skid entry when present) plus concurrent input
        drive(1'b1, 1'b0, 1'b0, 5'b01000, 32'hA0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'b01000, 32'hB0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 5'b01000, 32'hC0, 1'b0, 32'h0);
        step();
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_RegWrite", bus.RegWrite, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 5'b0, 32'h0, 1'b0, 32'h0);
        step();
        chk("flush_no_skid_left", bus.out_valid, 1'b0);

        // Asynchronous reset while stalled with entries held
        drive(1'b1, 1'b0, 1'b0, 5'b11110, 32'hD0, 1'b1, 32'h123);
        step();
        drive(1'b1, 1'b0, 1'b0, 5'b11110, 32'hE0, 1'b1, 32'h456);
        step();
        #3 reset = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        q.delete();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midreset_in_ready", bus.in_ready, 1'b1);
        chk("midreset_out_valid", bus.out_valid, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 5'b0, 32'h0, 1'b0, 32'h0);
        step();

        // Random traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) != 0, 5'($urandom), $urandom,
                  1'($urandom), $urandom);
            step();
        end
        drive(1'b0, 1'b0, 1'b1, 5'b0, 32'h0, 1'b0, 32'h0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
